key_switch_detect: RTL and testbench

// - Front-end stage of the lamp controller. Debounces the two active-low push keys and

---
 rtl/key_switch_detect.sv | 180 ++++++++++++++++++
 tb/tb_key_switch_detect.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_switch_detect.sv
// Purpose : debounce two active-low push keys and drive the emulated wall-switch level
//           (Key[0] toggles it, Key[1] runs a fixed-length off-then-on "flick").
// Latency : key_pulse DEBOUNCE_MS..DEBOUNCE_MS+1 ms after the synced edge (+2 sync cycles);
//           fake_switch/flick_busy follow key_pulse by one Sys_CLK.
// Flow    : no backpressure; every accepted press yields one key_pulse, auto-repeat never occurs.
//
// Ports:
//   Sys_CLK      in   system clock
//   Sys_RST      in   asynchronous active-high reset
//   Key[1:0]     in   raw keys, active-low, asynchronous to Sys_CLK
//   key_level    out  debounced key state, 1 = pressed
//   key_pulse    out  single-cycle pulse per accepted press
//   fake_switch  out  emulated switch level, 1 = on
//   flick_busy   out  high while a flick off-period is running
module key_switch_detect #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int FLICK_MS    = 200
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key,
  output logic [1:0] key_level,
  output logic [1:0] key_pulse,
  output logic       fake_switch,
  output logic       flick_busy
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW       = $clog2(DEBOUNCE_MS + 1);
  localparam int FW       = $clog2(FLICK_MS + 1);

  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_MS);
  localparam logic [FW-1:0] FL_MAX   = FW'(FLICK_MS);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  // Two-flop synchroniser; resets to the idle (released) key level.
  logic [1:0] key_meta;
  logic [1:0] key_sync;

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      key_meta <= 2'b11;
      key_sync <= 2'b11;
    end else begin
      key_meta <= Key;
      key_sync <= key_meta;
    end
  end

  // Free-running 1 ms tick prescaler.
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == TICK_MAX);

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Per-key debounce FSM. The check states require DEBOUNCE_MS+1 ticks with the new
  // level held: the first tick may land anywhere in the first millisecond, so this
  // guarantees at least DEBOUNCE_MS full milliseconds of stability.
  for (genvar i = 0; i < 2; i++) begin : g_key
    key_state_t    state;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pulse;

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
      if (Sys_RST) begin
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse     = 1'b0;
      unique case (state)
        RELEASED: begin
          if (!key_sync[i]) begin
            state_nxt = PRESS_CHK;
            cnt_nxt   = '0;
          end
        end
        PRESS_CHK: begin
          if (key_sync[i]) begin
            state_nxt = RELEASED;
          end else if (tick) begin
            if (cnt == DB_MAX) begin
              state_nxt = PRESSED;
              pulse     = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (key_sync[i]) begin
            state_nxt = RELEASE_CHK;
            cnt_nxt   = '0;
          end
        end
        RELEASE_CHK: begin
          if (!key_sync[i]) begin
            state_nxt = PRESSED;
          end else if (tick) begin
            if (cnt == DB_MAX) begin
              state_nxt = RELEASED;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    // The pulse is the accept transition itself: it is built only from registered
    // state, the registered synced key and the registered prescaler, so it is clean.
    assign key_pulse[i] = pulse;
    assign key_level[i] = (state == PRESSED) || (state == RELEASE_CHK);
  end

  // Switch / flick control.
  logic [FW-1:0] flick_cnt;

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      fake_switch <= 1'b0;
      flick_busy  <= 1'b0;
      flick_cnt   <= '0;
    end else if (key_pulse[0]) begin
      // A toggle always wins; during a flick it aborts with the switch left off.
      if (flick_busy) begin
        fake_switch <= 1'b0;
        flick_busy  <= 1'b0;
        flick_cnt   <= '0;
      end else begin
        fake_switch <= ~fake_switch;
      end
    end else if (key_pulse[1] && fake_switch && !flick_busy) begin
      fake_switch <= 1'b0;
      flick_busy  <= 1'b1;
      flick_cnt   <= '0;
    end else if (flick_busy) begin
      if (flick_cnt == FL_MAX) begin
        fake_switch <= 1'b1;
        flick_busy  <= 1'b0;
        flick_cnt   <= '0;
      end else if (tick) begin
        flick_cnt <= flick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_switch_detect.sv
// Directed bench for key_switch_detect with a 10-cycle tick, 3 ms debounce, 5 ms flick.
module tb_key_switch_detect;

  logic       clk;
  logic       Sys_RST;
  logic [1:0] Key;
  logic [1:0] key_level;
  logic [1:0] key_pulse;
  logic       fake_switch;
  logic       flick_busy;

  int checks;
  int passed;
  int pc0;
  int pc1;

  key_switch_detect #(
    .CLK_HZ     (10_000),
    .DEBOUNCE_MS(3),
    .FLICK_MS   (5)
  ) dut (
    .Sys_CLK    (clk),
    .Sys_RST    (Sys_RST),
    .Key        (Key),
    .key_level  (key_level),
    .key_pulse  (key_pulse),
    .fake_switch(fake_switch),
    .flick_busy (flick_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (key_pulse[0] === 1'b1) pc0++;
    if (key_pulse[1] === 1'b1) pc1++;
  end

  // Waits (bounded) for key_pulse[b]; lat = negedges elapsed, -1 if none.
  task automatic wait_pulse(input int b, input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (key_pulse[b] === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Press and release Key[0] once, leaving the switch toggled.
  task automatic toggle_key0;
    int lat;
    Key[0] = 1'b0;
    wait_pulse(0, 60, lat);
    @(negedge clk);
    Key[0] = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_reset;
    Sys_RST = 1'b0;
    Key     = 2'b11;
    #2 Sys_RST = 1'b1;
    #1;
    checks++; if (key_level !== 2'b00) $display("FAIL reset_key_level got=%b exp=00", key_level); else passed++;
    checks++; if (key_pulse !== 2'b00) $display("FAIL reset_key_pulse got=%b exp=00", key_pulse); else passed++;
    checks++; if (fake_switch !== 1'b0) $display("FAIL reset_fake_switch got=%b exp=0", fake_switch); else passed++;
    checks++; if (flick_busy !== 1'b0) $display("FAIL reset_flick_busy got=%b exp=0", flick_busy); else passed++;
    repeat (3) @(negedge clk);
    Sys_RST = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_press;
    int lat;
    pc0 = 0;
    Key[0] = 1'b0;
    wait_pulse(0, 60, lat);
    checks++; if (lat < 32 || lat > 42) $display("FAIL press_latency got=%0d exp=32..42", lat); else passed++;
    checks++; if (fake_switch !== 1'b0) $display("FAIL fake_before_pulse got=%b exp=0", fake_switch); else passed++;
    @(negedge clk);
    checks++; if (fake_switch !== 1'b1) $display("FAIL fake_toggle_on got=%b exp=1", fake_switch); else passed++;
    checks++; if (key_level[0] !== 1'b1) $display("FAIL key_level_pressed got=%b exp=1", key_level[0]); else passed++;
    repeat (60) @(negedge clk);
    checks++; if (pc0 !== 1) $display("FAIL hold_single_pulse got=%0d exp=1", pc0); else passed++;
    Key[0] = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (key_level[0] !== 1'b0) $display("FAIL key_level_released got=%b exp=0", key_level[0]); else passed++;
    checks++; if (pc0 !== 1) $display("FAIL no_release_pulse got=%0d exp=1", pc0); else passed++;
    Key[0] = 1'b0;
    wait_pulse(0, 60, lat);
    checks++; if (lat < 32 || lat > 42) $display("FAIL second_press_latency got=%0d exp=32..42", lat); else passed++;
    @(negedge clk);
    checks++; if (fake_switch !== 1'b0) $display("FAIL fake_toggle_off got=%b exp=0", fake_switch); else passed++;
    Key[0] = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_bounce;
    int lat;
    pc0 = 0;
    for (int n = 0; n < 3; n++) begin
      Key[0] = 1'b0;
      repeat (10) @(negedge clk);
      Key[0] = 1'b1;
      repeat (10) @(negedge clk);
    end
    checks++; if (pc0 !== 0) $display("FAIL bounce_no_pulse got=%0d exp=0", pc0); else passed++;
    Key[0] = 1'b0;
    wait_pulse(0, 60, lat);
    checks++; if (lat < 32 || lat > 42) $display("FAIL bounce_latency got=%0d exp=32..42", lat); else passed++;
    repeat (20) @(negedge clk);
    checks++; if (pc0 !== 1) $display("FAIL bounce_single_pulse got=%0d exp=1", pc0); else passed++;
    checks++; if (fake_switch !== 1'b1) $display("FAIL bounce_fake_on got=%b exp=1", fake_switch); else passed++;
    Key[0] = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_flick;
    int lat;
    int dur;
    int early;
    Key[1] = 1'b0;
    wait_pulse(1, 60, lat);
    checks++; if (lat < 32 || lat > 42) $display("FAIL flick_key_latency got=%0d exp=32..42", lat); else passed++;
    @(negedge clk);
    checks++; if (fake_switch !== 1'b0) $display("FAIL flick_fake_off got=%b exp=0", fake_switch); else passed++;
    checks++; if (flick_busy !== 1'b1) $display("FAIL flick_busy_set got=%b exp=1", flick_busy); else passed++;
    dur   = -1;
    early = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (flick_busy !== 1'b1) begin
        dur = n;
        break;
      end
      if (fake_switch !== 1'b0) early = 1;
    end
    checks++; if (dur < 40 || dur > 60) $display("FAIL flick_duration got=%0d exp=40..60", dur); else passed++;
    checks++; if (fake_switch !== 1'b1) $display("FAIL flick_end_fake got=%b exp=1", fake_switch); else passed++;
    checks++; if (early !== 0) $display("FAIL flick_fake_held_low got=%0d exp=0", early); else passed++;
    Key[1] = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_ignore;
    int lat;
    toggle_key0();
    checks++; if (fake_switch !== 1'b0) $display("FAIL ignore_setup_off got=%b exp=0", fake_switch); else passed++;
    Key[1] = 1'b0;
    wait_pulse(1, 60, lat);
    checks++; if (lat < 32 || lat > 42) $display("FAIL ignore_key1_latency got=%0d exp=32..42", lat); else passed++;
    @(negedge clk);
    checks++; if (fake_switch !== 1'b0) $display("FAIL ignore_fake got=%b exp=0", fake_switch); else passed++;
    checks++; if (flick_busy !== 1'b0) $display("FAIL ignore_busy got=%b exp=0", flick_busy); else passed++;
    Key[1] = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  // Key[0] goes down 20 cycles after Key[1]; both debouncers see the same tick
  // phase, so pulse 0 lands exactly 20 cycles into the flick.
  task automatic test_cancel;
    int lat;
    int rose;
    toggle_key0();
    Key[1] = 1'b0;
    repeat (20) @(negedge clk);
    Key[0] = 1'b0;
    wait_pulse(1, 60, lat);
    @(negedge clk);
    checks++; if (flick_busy !== 1'b1) $display("FAIL cancel_flick_started got=%b exp=1", flick_busy); else passed++;
    wait_pulse(0, 60, lat);
    checks++; if (flick_busy !== 1'b1) $display("FAIL busy_before_cancel got=%b exp=1", flick_busy); else passed++;
    @(negedge clk);
    checks++; if (flick_busy !== 1'b0) $display("FAIL cancel_busy_fall got=%b exp=0", flick_busy); else passed++;
    checks++; if (fake_switch !== 1'b0) $display("FAIL cancel_fake_low got=%b exp=0", fake_switch); else passed++;
    rose = 0;
    repeat (80) begin
      @(negedge clk);
      if (fake_switch !== 1'b0) rose = 1;
    end
    checks++; if (rose !== 0) $display("FAIL cancel_no_late_rise got=%0d exp=0", rose); else passed++;
    Key = 2'b11;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_simultaneous;
    int lat;
    int bad;
    toggle_key0();
    Key = 2'b00;
    wait_pulse(0, 60, lat);
    checks++; if (key_pulse[1] !== 1'b1) $display("FAIL simul_both_pulses got=%b exp=1", key_pulse[1]); else passed++;
    @(negedge clk);
    checks++; if (fake_switch !== 1'b0) $display("FAIL simul_fake got=%b exp=0", fake_switch); else passed++;
    checks++; if (flick_busy !== 1'b0) $display("FAIL simul_busy got=%b exp=0", flick_busy); else passed++;
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (fake_switch !== 1'b0 || flick_busy !== 1'b0) bad = 1;
    end
    checks++; if (bad !== 0) $display("FAIL simul_no_flick got=%0d exp=0", bad); else passed++;
    Key = 2'b11;
    repeat (50) @(negedge clk);
  endtask

  task automatic test_reset_mid_flick;
    int lat;
    int bad;
    toggle_key0();
    Key[1] = 1'b0;
    wait_pulse(1, 60, lat);
    repeat (10) @(negedge clk);
    checks++; if (flick_busy !== 1'b1 || key_level !== 2'b10) $display("FAIL pre_reset_state got busy=%b level=%b exp busy=1 level=10", flick_busy, key_level); else passed++;
    #2 Sys_RST = 1'b1;
    #1;
    checks++; if (fake_switch !== 1'b0) $display("FAIL async_reset_fake got=%b exp=0", fake_switch); else passed++;
    checks++; if (flick_busy !== 1'b0) $display("FAIL async_reset_busy got=%b exp=0", flick_busy); else passed++;
    checks++; if (key_level !== 2'b00) $display("FAIL async_reset_level got=%b exp=00", key_level); else passed++;
    Key = 2'b11;
    @(negedge clk);
    Sys_RST = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (fake_switch !== 1'b0 || flick_busy !== 1'b0 || key_pulse !== 2'b00) bad = 1;
    end
    checks++; if (bad !== 0) $display("FAIL post_reset_idle got=%0d exp=0", bad); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  initial begin
    checks  = 0;
    passed  = 0;
    pc0     = 0;
    pc1     = 0;
    Sys_RST = 1'b0;
    Key     = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_flick();
    test_ignore();
    test_cancel();
    test_simultaneous();
    test_reset_mid_flick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
